// File: rtl/frogger_game_ctrl_if.sv
// Signal bundle between the frogger game sequencer and the rest of the top level.
// The slave side is the sequencer. The master side is the pixel/collision logic and VGA timing.
`timescale 1ns/1ps
interface frogger_game_ctrl_if;
    logic        frame_start;
    logic        start_btn;
    logic        collision;
    logic        goal_reached;
    logic        row_advance;
    logic [2:0]  state;
    logic        lane_enable;
    logic        input_enable;
    logic        frog_reset;
    logic [21:0] lane_div;
    logic [2:0]  lives;
    logic [2:0]  level;
    logic [15:0] score;
    logic        game_over;

    modport master (
        output frame_start, start_btn, collision, goal_reached, row_advance,
        input  state, lane_enable, input_enable, frog_reset, lane_div,
               lives, level, score, game_over
    );

    modport slave (
        input  frame_start, start_btn, collision, goal_reached, row_advance,
        output state, lane_enable, input_enable, frog_reset, lane_div,
               lives, level, score, game_over
    );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: play/death/level-up/game-over flow, lives, score and level,
// lane mover gating and speed divider, and frog respawn pulses.
`timescale 1ns/1ps
module frogger_game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int LEVEL_MAX    = 7,
    parameter int DIV_BASE     = 2000000,
    parameter int DIV_STEP     = 200000,
    parameter int PAUSE_FRAMES = 60,
    parameter int ROW_POINTS   = 10,
    parameter int GOAL_POINTS  = 100
) (
    input logic               CLOCK_50,
    input logic               reset_n,
    frogger_game_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int          CNT_W     = $clog2(PAUSE_FRAMES + 1);
    localparam logic [2:0]  LIVES_W   = 3'(LIVES_INIT);
    localparam logic [2:0]  LEVEL_TOP = 3'(LEVEL_MAX);
    localparam logic [21:0] BASE_W    = 22'(DIV_BASE);
    localparam logic [21:0] STEP_W    = 22'(DIV_STEP);
    localparam logic [16:0] ROW_PTS   = 17'(ROW_POINTS);
    localparam logic [16:0] GOAL_PTS  = 17'(GOAL_POINTS);

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [2:0]         level_q, level_d;
    logic [15:0]        score_q, score_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [21:0]        lane_div_q;
    logic               start_q, start_press, load;
    logic               lane_en_q, frog_reset_q, game_over_q;

    // Score never wraps: any carry out of 16 bits pins it at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
        logic [16:0] s;
        s = {1'b0, a} + b;
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign start_press = start_q & ~bus.start_btn;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_press) begin
                    state_d = S_PLAY;
                    load    = 1'b1;
                    lives_d = LIVES_W;
                    level_d = '0;
                    score_d = '0;
                end
            end
            S_PLAY: begin
                if (bus.collision) begin
                    state_d = S_DYING;
                    if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                    cnt_d   = '0;
                end else if (bus.goal_reached) begin
                    state_d = S_LEVEL_UP;
                    score_d = sat_add(score_q, GOAL_PTS);
                    if (level_q != LEVEL_TOP) level_d = level_q + 3'd1;
                    cnt_d   = '0;
                end else if (bus.row_advance) begin
                    score_d = sat_add(score_q, ROW_PTS);
                end
            end
            S_DYING, S_LEVEL_UP: begin
                if (bus.frame_start) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(PAUSE_FRAMES))
                        state_d = (state_q == S_DYING && lives_q == 3'd0) ? S_GAME_OVER : S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            lives_q      <= '0;
            level_q      <= '0;
            score_q      <= '0;
            cnt_q        <= '0;
            lane_div_q   <= BASE_W;
            start_q      <= 1'b1;
            lane_en_q    <= 1'b0;
            frog_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            lives_q      <= lives_d;
            level_q      <= level_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            start_q      <= bus.start_btn;
            lane_div_q   <= load ? BASE_W : BASE_W - 22'(level_q) * STEP_W;
            lane_en_q    <= (state_d == S_PLAY);
            frog_reset_q <= (state_d == S_PLAY) && (state_q != S_PLAY);
            game_over_q  <= (state_d == S_GAME_OVER);
        end
    end

    assign bus.state        = state_q;
    assign bus.lane_enable  = lane_en_q;
    assign bus.input_enable = lane_en_q;
    assign bus.frog_reset   = frog_reset_q;
    assign bus.lane_div     = lane_div_q;
    assign bus.lives        = lives_q;
    assign bus.level        = level_q;
    assign bus.score        = score_q;
    assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed and randomized bench for frogger_game_ctrl against a per-edge behavioural model
// of the game rules.
`timescale 1ns/1ps
module tb_frogger_game_ctrl;
    localparam int DIV_BASE = 2000000;
    localparam int DIV_STEP = 200000;
    localparam int PAUSE    = 60;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    frogger_game_ctrl_if bus();

    frogger_game_ctrl dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Game model: 0 idle, 1 play, 2 dying, 3 level-up, 4 game over.
    int m_state, m_lives, m_level, m_score, m_frames;
    bit m_btn_prev;
    int e_div;
    bit e_run, e_frog, e_over;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit fs, input bit sb,
                              input bit col, input bit goal, input bit row);
        int  old_state;
        int  old_level;
        bit  pressed;
        bit  restarted;
        old_state = m_state;
        old_level = m_level;
        restarted = 1'b0;
        if (!r) begin
            m_state = 0; m_lives = 0; m_level = 0; m_score = 0; m_frames = 0;
            m_btn_prev = 1'b1;
            e_div = DIV_BASE; e_run = 1'b0; e_frog = 1'b0; e_over = 1'b0;
            return;
        end
        pressed    = m_btn_prev && !sb;
        m_btn_prev = sb;
        if (old_state == 0 || old_state == 4) begin
            if (pressed) begin
                m_state = 1; m_lives = 3; m_level = 0; m_score = 0; restarted = 1'b1;
            end
        end else if (old_state == 1) begin
            if (col) begin
                m_state = 2; m_lives = m_lives - 1; m_frames = 0;
            end else if (goal) begin
                m_state = 3; m_frames = 0;
                m_score = (m_score + 100 > 65535) ? 65535 : m_score + 100;
                m_level = (m_level < 7) ? m_level + 1 : 7;
            end else if (row) begin
                m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
            end
        end else if (fs) begin
            m_frames++;
            if (m_frames == PAUSE) m_state = (old_state == 2 && m_lives == 0) ? 4 : 1;
        end
        e_div  = restarted ? DIV_BASE : DIV_BASE - old_level * DIV_STEP;
        e_run  = (m_state == 1);
        e_frog = (m_state == 1) && (old_state != 1);
        e_over = (m_state == 4);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},     32'(bus.state),        32'(m_state));
        check({tag, ".lives"},     32'(bus.lives),        32'(m_lives));
        check({tag, ".level"},     32'(bus.level),        32'(m_level));
        check({tag, ".score"},     32'(bus.score),        32'(m_score));
        check({tag, ".lane_div"},  32'(bus.lane_div),     32'(e_div));
        check({tag, ".lane_en"},   32'(bus.lane_enable),  32'(e_run));
        check({tag, ".input_en"},  32'(bus.input_enable), 32'(e_run));
        check({tag, ".frog_rst"},  32'(bus.frog_reset),   32'(e_frog));
        check({tag, ".game_over"}, 32'(bus.game_over),    32'(e_over));
    endtask

    task automatic cycle(input bit r, input bit fs, input bit sb, input bit col,
                         input bit goal, input bit row, input string tag);
        @(negedge clk);
        reset_n          = r;
        bus.frame_start  = fs;
        bus.start_btn    = sb;
        bus.collision    = col;
        bus.goal_reached = goal;
        bus.row_advance  = row;
        model_edge(r, fs, sb, col, goal, row);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Pause frames interleaved with idle cycles; event inputs are randomized since they must be ignored.
    task automatic pause(input string tag);
        for (int i = 0; i < PAUSE; i++) begin
            cycle(1, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
            cycle(1, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.start_btn = 1'b1; bus.collision = 1'b0;
        bus.goal_reached = 1'b0; bus.row_advance = 1'b0;

        // Reset and start.
        repeat (3) cycle(0, 0, 1, 0, 0, 0, "rst");
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_div", 32'(bus.lane_div), 32'd2000000);
        cycle(1, 0, 1, 0, 0, 0, "idle");
        cycle(1, 0, 0, 0, 0, 0, "start");
        check("t1_state", 32'(bus.state), 32'd1);
        check("t1_lives", 32'(bus.lives), 32'd3);
        check("t1_frog", 32'(bus.frog_reset), 32'd1);
        check("t1_div", 32'(bus.lane_div), 32'd2000000);
        cycle(1, 0, 0, 0, 0, 0, "held");
        check("t1_frog_off", 32'(bus.frog_reset), 32'd0);
        check("t1_held", 32'(bus.state), 32'd1);
        cycle(1, 0, 1, 0, 0, 0, "release");

        // Single death and recovery.
        cycle(1, 0, 1, 1, 0, 0, "t2_col");
        check("t2_state", 32'(bus.state), 32'd2);
        check("t2_lives", 32'(bus.lives), 32'd2);
        check("t2_lane", 32'(bus.lane_enable), 32'd0);
        pause("t2_pause");
        check("t2_back", 32'(bus.state), 32'd1);
        check("t2_frog", 32'(bus.frog_reset), 32'd1);

        // Run out of lives, then restart from game over.
        repeat (3) cycle(1, 0, 1, 0, 0, 1, "t3_row");
        cycle(1, 0, 1, 1, 0, 0, "t3_col2");
        pause("t3_pause2");
        cycle(1, 0, 1, 1, 0, 0, "t3_col3");
        pause("t3_pause3");
        check("t3_state", 32'(bus.state), 32'd4);
        check("t3_over", 32'(bus.game_over), 32'd1);
        check("t3_lives", 32'(bus.lives), 32'd0);
        check("t3_score_held", 32'(bus.score), 32'd30);
        cycle(1, 0, 0, 0, 0, 0, "t3_restart");
        check("t3_play", 32'(bus.state), 32'd1);
        check("t3_score", 32'(bus.score), 32'd0);
        cycle(1, 0, 1, 0, 0, 0, "release");

        // Level-ups up to saturation.
        cycle(1, 0, 1, 0, 1, 0, "t4_goal");
        check("t4_score", 32'(bus.score), 32'd100);
        check("t4_level", 32'(bus.level), 32'd1);
        cycle(1, 0, 1, 0, 0, 0, "t4_div");
        check("t4_div1", 32'(bus.lane_div), 32'd1800000);
        pause("t4_pause");
        for (int g = 1; g < 8; g++) begin
            cycle(1, 0, 1, 0, 1, 0, "t4_goal_n");
            pause("t4_pause_n");
        end
        check("t4_level_sat", 32'(bus.level), 32'd7);
        check("t4_div_sat", 32'(bus.lane_div), 32'd600000);
        check("t4_score8", 32'(bus.score), 32'd800);

        // Event priority and score saturation.
        cycle(1, 0, 1, 1, 1, 1, "t5_all");
        check("t5_state", 32'(bus.state), 32'd2);
        check("t5_score", 32'(bus.score), 32'd800);
        pause("t5_pause");
        for (int k = 0; k < 6473; k++) cycle(1, 0, 1, 0, 0, 1, "t5_rows");
        check("t5_65530", 32'(bus.score), 32'd65530);
        cycle(1, 0, 1, 0, 0, 1, "t5_sat");
        check("t5_65535", 32'(bus.score), 32'd65535);
        cycle(1, 0, 1, 0, 0, 1, "t5_sat2");
        check("t5_hold", 32'(bus.score), 32'd65535);

        // Reset in the middle of a death pause.
        cycle(0, 0, 1, 0, 0, 0, "t6_rst");
        cycle(1, 0, 0, 0, 0, 0, "t6_start");
        cycle(1, 0, 1, 0, 1, 0, "t6_goal1");
        pause("t6_p1");
        cycle(1, 0, 1, 0, 1, 0, "t6_goal2");
        pause("t6_p2");
        repeat (4) cycle(1, 0, 1, 0, 0, 1, "t6_row");
        check("t6_240", 32'(bus.score), 32'd240);
        cycle(1, 0, 1, 1, 0, 0, "t6_col");
        repeat (5) cycle(1, 1, 1, 0, 0, 0, "t6_dying");
        cycle(0, 0, 0, 0, 0, 0, "t6_reset");
        check("t6_state", 32'(bus.state), 32'd0);
        check("t6_score", 32'(bus.score), 32'd0);
        check("t6_lives", 32'(bus.lives), 32'd0);
        check("t6_div", 32'(bus.lane_div), 32'd2000000);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, "t6_held");
        check("t6_no_restart", 32'(bus.state), 32'd0);
        cycle(0, 0, 1, 0, 0, 0, "t6_rel");

        // Randomized play against the model.
        for (int n = 0; n < 4000; n++) begin
            cycle(1'($urandom_range(0, 499) != 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 3) == 0),
                  "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
